fir_engine_ctrl: RTL

Sequencing controller for the FIR engine. It accepts one input sample per AXI-Stream handshake, writes it into the data RAM's circular shift buffer, and runs Tape_Num multiply-accumulate steps against the tap RAM. It then presents the result on the output stream and tracks completion against the configured data length. It sits between the AXI-Lite config block (which supplies ap_start, data_length and done_clr, and owns the tap RAM while the engine is idle) and the tap/data BRAMs.

---
 rtl/fir_engine_ctrl.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/fir_engine_ctrl.sv
// FIR engine sequencer: takes one AXI-Stream sample at a time, shifts it into a
// circular data buffer, runs Tape_Num MACs against the tap RAM and streams the result out.
module fir_engine_ctrl #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int Tape_Num    = 11
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst,
  input  logic                   ap_start,
  input  logic [31:0]            data_length,
  input  logic                   done_clr,
  output logic                   ap_idle,
  output logic                   ap_done,
  output logic                   tlast_err,
  input  logic [pDATA_WIDTH-1:0] ss_tdata,
  input  logic                   ss_tvalid,
  input  logic                   ss_tlast,
  output logic                   ss_tready,
  output logic [pDATA_WIDTH-1:0] sm_tdata,
  output logic                   sm_tvalid,
  output logic                   sm_tlast,
  input  logic                   sm_tready,
  output logic                   tap_EN,
  output logic [pADDR_WIDTH-1:0] tap_A,
  input  logic [pDATA_WIDTH-1:0] tap_Do,
  output logic                   data_EN,
  output logic [3:0]             data_WE,
  output logic [pADDR_WIDTH-1:0] data_A,
  output logic [pDATA_WIDTH-1:0] data_Di,
  input  logic [pDATA_WIDTH-1:0] data_Do
);

  localparam int CW = $clog2(Tape_Num + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(Tape_Num - 1);
  localparam logic [CW-1:0] TAPS     = CW'(Tape_Num);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CLEAR   = 3'd1;
  localparam logic [2:0] S_WAIT_IN = 3'd2;
  localparam logic [2:0] S_MAC     = 3'd3;
  localparam logic [2:0] S_OUT     = 3'd4;

  logic [2:0]             r_state;
  logic [CW-1:0]          r_cnt;
  logic [CW-1:0]          r_wr_ptr;
  logic [31:0]            r_out_cnt;
  logic [31:0]            r_len;
  logic [pDATA_WIDTH-1:0] r_acc;
  logic                   r_ap_done;
  logic                   r_tlast_err;

  logic                   w_is_last;
  logic                   w_mac_rd;
  logic [CW-1:0]          w_rd_idx;
  logic [pDATA_WIDTH-1:0] w_product;
  logic                   w_done_set;
  logic                   w_done_clr;

  function automatic logic [pADDR_WIDTH-1:0] word_addr(input logic [CW-1:0] idx);
    return pADDR_WIDTH'({idx, 2'b00});
  endfunction

  assign w_is_last = (r_out_cnt == r_len - 32'd1);
  assign w_mac_rd  = (r_state == S_MAC) && (r_cnt < TAPS);
  // Newest sample sits at wr_ptr; tap k pairs with the sample k positions older.
  assign w_rd_idx  = (r_wr_ptr >= r_cnt) ? (r_wr_ptr - r_cnt)
                                         : (r_wr_ptr + TAPS - r_cnt);
  assign w_product = tap_Do * data_Do;

  assign w_done_set = ((r_state == S_CLEAR) && (r_cnt == LAST_IDX) && (r_len == 32'd0)) ||
                      ((r_state == S_OUT) && sm_tready && w_is_last);
  assign w_done_clr = done_clr || ((r_state == S_IDLE) && ap_start);

  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_wr_ptr    <= '0;
      r_out_cnt   <= '0;
      r_len       <= '0;
      r_acc       <= '0;
      r_tlast_err <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (ap_start) begin
            r_len       <= data_length;
            r_tlast_err <= 1'b0;
            r_cnt       <= '0;
            r_wr_ptr    <= '0;
            r_out_cnt   <= '0;
            r_state     <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          if (r_cnt == LAST_IDX) begin
            r_cnt   <= '0;
            r_state <= (r_len == 32'd0) ? S_IDLE : S_WAIT_IN;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_WAIT_IN: begin
          if (ss_tvalid) begin
            r_acc <= '0;
            r_cnt <= '0;
            if (ss_tlast != w_is_last) r_tlast_err <= 1'b1;
            r_state <= S_MAC;
          end
        end
        S_MAC: begin
          // RAM data lags the address by one cycle, so accumulation runs k=1..Tape_Num.
          if (r_cnt != '0) r_acc <= r_acc + w_product;
          if (r_cnt == TAPS) begin
            r_cnt    <= '0;
            r_wr_ptr <= (r_wr_ptr == LAST_IDX) ? '0 : r_wr_ptr + 1'b1;
            r_state  <= S_OUT;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_OUT: begin
          if (sm_tready) begin
            r_out_cnt <= r_out_cnt + 32'd1;
            r_state   <= w_is_last ? S_IDLE : S_WAIT_IN;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      r_ap_done <= 1'b0;
    end else if (w_done_set) begin
      r_ap_done <= 1'b1;
    end else if (w_done_clr) begin
      r_ap_done <= 1'b0;
    end
  end

  assign ap_idle   = (r_state == S_IDLE);
  assign ap_done   = r_ap_done;
  assign tlast_err = r_tlast_err;
  assign ss_tready = (r_state == S_WAIT_IN);
  assign sm_tvalid = (r_state == S_OUT);
  assign sm_tlast  = (r_state == S_OUT) && w_is_last;
  assign sm_tdata  = (r_state == S_OUT) ? r_acc : '0;
  assign tap_EN    = w_mac_rd;
  assign tap_A     = w_mac_rd ? word_addr(r_cnt) : '0;

  always_comb begin
    data_EN = 1'b0;
    data_WE = 4'h0;
    data_A  = '0;
    data_Di = '0;
    case (r_state)
      S_CLEAR: begin
        data_EN = 1'b1;
        data_WE = 4'hf;
        data_A  = word_addr(r_cnt);
      end
      S_WAIT_IN: begin
        if (ss_tvalid) begin
          data_EN = 1'b1;
          data_WE = 4'hf;
          data_A  = word_addr(r_wr_ptr);
          data_Di = ss_tdata;
        end
      end
      S_MAC: begin
        if (w_mac_rd) begin
          data_EN = 1'b1;
          data_A  = word_addr(w_rd_idx);
        end
      end
      default: ;
    endcase
  end

endmodule
